// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues sequential word requests to instruction memory and queues the responses.
// It hands {instr, pc} pairs to decode in order, and a redirect flushes the queue.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req_valid,
  output logic [31:0]                 imem_req_addr,
  input  logic                        imem_req_ready,
  input  logic                        imem_resp_valid,
  input  logic [31:0]                 imem_resp_data,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        dec_valid,
  output logic [31:0]                 dec_instr,
  output logic [31:0]                 dec_pc,
  input  logic                        dec_ready,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);

  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   instr_q [FQ_DEPTH];
  logic [31:0]   pc_q    [FQ_DEPTH];

  logic [CW:0]   credit;
  logic [31:0]   redirect_aligned;
  logic          accept;
  logic          push;
  logic          pop;

  // In-flight requests plus queued entries never exceed the queue size.
  // Because of this, a returning response always finds a free slot.
  assign credit           = {1'b0, outstanding} + {1'b0, count};
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  assign imem_req_valid = !rst && !redirect_valid && (credit < (CW+1)'(FQ_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign push = imem_resp_valid && !redirect_valid && (drop_cnt == '0);

  assign dec_valid = (count != '0) && !redirect_valid;
  assign dec_instr = (count != '0) ? instr_q[rd_ptr] : 32'h0;
  assign dec_pc    = (count != '0) ? pc_q[rd_ptr]    : 32'h0;
  assign pop       = dec_valid && dec_ready;
  assign fq_count  = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc    <= redirect_aligned;
      resp_pc     <= redirect_aligned;
      outstanding <= outstanding - CW'(imem_resp_valid);
      drop_cnt    <= outstanding - CW'(imem_resp_valid);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (accept)
        fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid);
      if (imem_resp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);
      if (push) begin
        instr_q[wr_ptr] <= imem_resp_data;
        pc_q[wr_ptr]    <= resp_pc;
        wr_ptr          <= wr_ptr + AW'(1);
        resp_pc         <= resp_pc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      assert (!(push && (count == CW'(FQ_DEPTH))));
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit, built around a latency-configurable memory model.
// A scoreboard of expected {pc, instr} pairs is filled on accept and drained on decode.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FQ_DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic [2:0]  fq_count;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .dec_valid(dec_valid), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_ready(dec_ready), .fq_count(fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit live; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  pend_t       pend[$];
  exp_t        sb[$];
  int          qcnt;
  logic [31:0] exp_fetch;
  int          cyc;
  int          lat;
  bit          mem_ready;
  bit          dec_rdy;
  int          n_acc;
  int          first_acc;
  int          first_dv;
  int          vectors;
  int          miscompares;
  logic [31:0] hold_addr;
  bit          found;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    imem_req_ready = 1'b0;
    dec_ready = 1'b0;
    #1;
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pend.delete();
    sb.delete();
    qcnt = 0;
    exp_fetch = RESET_PC;
    n_acc = 0;
    first_acc = -1;
    first_dv = -1;
    cyc++;
    #1;
    checkOutput("post_rst_fq_count", 32'(fq_count), 32'h0);
    checkOutput("post_rst_dec_valid", 32'(dec_valid), 32'h0);
    checkOutput("post_rst_req_addr", imem_req_addr, RESET_PC);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic applyStimulus(input bit redir, input logic [31:0] target);
    bit    resp_now;
    bit    exp_rv;
    bit    exp_dv;
    pend_t p;
    exp_t  e;
    resp_now = (pend.size() > 0) && (pend[0].due == cyc);
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? (pend[0].addr >> 2) : 32'hDEAD_BEEF;
    imem_req_ready  = mem_ready;
    dec_ready       = dec_rdy;
    redirect_valid  = redir;
    redirect_pc     = target;
    #1;
    exp_rv = !redir && ((pend.size() + qcnt) < FQ_DEPTH);
    exp_dv = (qcnt != 0) && !redir;
    checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (imem_req_valid && exp_rv)
      checkOutput("req_addr", imem_req_addr, exp_fetch);
    checkOutput("dec_valid", 32'(dec_valid), 32'(exp_dv));
    checkOutput("fq_count", 32'(fq_count), 32'(qcnt));
    if (qcnt == 0) begin
      checkOutput("empty_dec_instr", dec_instr, 32'h0);
      checkOutput("empty_dec_pc", dec_pc, 32'h0);
    end
    if (imem_req_valid && mem_ready) begin
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (dec_valid && first_dv < 0) first_dv = cyc;
    if (exp_dv && dec_rdy) begin
      checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'h1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("dec_pc", dec_pc, e.pc);
        checkOutput("dec_instr", dec_instr, e.instr);
        qcnt--;
      end
    end
    if (resp_now) begin
      p = pend.pop_front();
      if (p.live && !redir) qcnt++;
    end
    if (exp_rv && mem_ready) begin
      pend.push_back('{addr: exp_fetch, due: cyc + lat, live: 1'b1});
      sb.push_back('{pc: exp_fetch, instr: exp_fetch >> 2});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redir) begin
      sb.delete();
      qcnt = 0;
      foreach (pend[i]) pend[i].live = 1'b0;
      exp_fetch = {target[31:2], 2'b00};
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    lat = 1;
    mem_ready = 1'b1;
    dec_rdy = 1'b1;

    // Streaming fetch with single-cycle memory.
    applyReset();
    repeat (10) applyStimulus(1'b0, 32'h0);
    checkOutput("first_dec_latency", 32'(first_dv - first_acc), 32'd2);

    // Decoder stalled: the queue fills, then drains in order.
    applyReset();
    dec_rdy = 1'b0;
    repeat (8) applyStimulus(1'b0, 32'h0);
    checkOutput("stall_accepts", 32'(n_acc), 32'd4);
    checkOutput("stall_fq_full", 32'(fq_count), 32'd4);
    checkOutput("stall_req_valid", 32'(imem_req_valid), 32'h0);
    dec_rdy = 1'b1;
    repeat (10) applyStimulus(1'b0, 32'h0);

    // Redirect with two requests in flight on a 3-cycle memory.
    applyReset();
    lat = 3;
    repeat (2) applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b1, 32'h100);
    checkOutput("redir_drop_cnt", 32'(dut.drop_cnt), 32'd2);
    checkOutput("redir_req_addr", imem_req_addr, 32'h100);
    repeat (10) applyStimulus(1'b0, 32'h0);

    // Memory not ready: request held with a stable address.
    lat = 1;
    mem_ready = 1'b0;
    repeat (3) applyStimulus(1'b0, 32'h0);
    hold_addr = imem_req_addr;
    repeat (5) applyStimulus(1'b0, 32'h0);
    checkOutput("hold_req_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("hold_req_addr", imem_req_addr, hold_addr);
    mem_ready = 1'b1;
    applyStimulus(1'b0, 32'h0);
    checkOutput("hold_advance", imem_req_addr, hold_addr + 32'd4);
    repeat (4) applyStimulus(1'b0, 32'h0);

    // Misaligned redirect landing on a response cycle.
    lat = 2;
    repeat (4) applyStimulus(1'b0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() > 0 && pend[0].due == cyc) found = 1'b1;
      else applyStimulus(1'b0, 32'h0);
    end
    checkOutput("resp_cycle_found", 32'(found), 32'h1);
    applyStimulus(1'b1, 32'h202);
    checkOutput("redir2_fq_count", 32'(fq_count), 32'h0);
    checkOutput("redir2_drop_cnt", 32'(dut.drop_cnt), 32'(pend.size()));
    checkOutput("redir2_req_addr", imem_req_addr, 32'h200);
    repeat (8) applyStimulus(1'b0, 32'h0);

    // Reset mid-stream with entries queued.
    lat = 1;
    dec_rdy = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (qcnt == 3) found = 1'b1;
      else applyStimulus(1'b0, 32'h0);
    end
    checkOutput("three_queued", 32'(found), 32'h1);
    applyReset();
    dec_rdy = 1'b1;
    repeat (6) applyStimulus(1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
